coh_req_arb: RTL and testbench
==============================

Name: coh_req_arb

Overview:
- Shares the single L2 coherence request port between NREQ L1 data caches (one per core) using round-robin arbitration.
- Tracks one outstanding miss per core and blocks a grant whose line address matches an in-flight miss, so the L2 never sees two concurrent transactions to one line.
- Routes L2 responses back to the owning core by destination ID.
- Sits between the per-core l1d coherence links and the shared L2 controller.

Parameters:
- NREQ, 4, number of requesting cores (power of two, 2..8); SRC_W = $clog2(NREQ).
- OFFSET_W, 5, line offset bits; line address = addr[31:OFFSET_W].
- CMD_W, 3, width of coh_types command field (GETS, GETM, DATA, DATA_EXCL, ...).
- LINE_W, 256, response line width in bits.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-core request valid.
- req_ready  out  NREQ  per-core request accepted; transfer when valid&&ready.
- req_cmd  in  NREQ*CMD_W  per-core command, packed, core i at [i*CMD_W +: CMD_W].
- req_addr  in  NREQ*32  per-core line-aligned address, packed.
- l2_req_valid  out  1  registered request to L2.
- l2_req_ready  in  1  L2 accepts request.
- l2_req_cmd  out  CMD_W  forwarded command.
- l2_req_addr  out  32  forwarded address, offset bits forced to 0.
- l2_req_src  out  SRC_W  granted core index.
- l2_resp_valid  in  1  L2 response valid.
- l2_resp_ready  out  1  response accepted.
- l2_resp_dst  in  SRC_W  destination core.
- l2_resp_cmd  in  CMD_W  response command.
- l2_resp_line  in  LINE_W  response data.
- resp_valid  out  NREQ  one-hot per-core response valid.
- resp_ready  in  NREQ  per-core response ready.
- resp_cmd  out  CMD_W  broadcast response command.
- resp_line  out  LINE_W  broadcast response data.

Behaviour:
- Reset (async, while rst=1): all outputs 0, rr_ptr=0, busy[NREQ]=0, out buffer empty. Reset mid-transaction drops the buffered request and all outstanding state. No retry.
- Eligibility of core i: req_valid[i] && !busy[i] && no conflict. Conflict means req_addr[i][31:OFFSET_W] equals the line of any busy core j≠i, or of the buffered l2 request.
- State machine:
  - EMPTY: out buffer empty. If any core is eligible, grant the first eligible index at or after rr_ptr, wrapping modulo NREQ.
    - req_ready[grant]=1 combinationally; only one req_ready high per cycle.
    - Next edge: latch cmd/addr/src into the buffer, set busy[grant]=1, rr_ptr = grant+1 mod NREQ, go to FULL.
  - FULL: l2_req_valid=1, fields held stable. On l2_req_ready: go to EMPTY. No same-cycle regrant; one request per 2 cycles maximum. All req_ready=0 in FULL.
- Latency: core handshake at edge N → l2_req_valid high from cycle N+1.
- Responses pass through combinationally:
  - resp_valid[l2_resp_dst] = l2_resp_valid.
  - l2_resp_ready = resp_ready[l2_resp_dst].
  - resp_cmd and resp_line mirror the L2 fields.
- On a response handshake with cmd DATA or DATA_EXCL: clear busy[dst]. Other response cmds (e.g. INV) do not change busy.
- Simultaneous busy-clear and new request from the same core in one cycle: the new request is not eligible until the next cycle (busy is a registered value).
- Response with dst ≥ NREQ (NREQ not a power of two is disallowed): not reachable. Assert in simulation.
- Arbitration is starvation-free: a continuously eligible core is granted within NREQ grants.

Test Plan:
- Reset, then core 2 GETS addr 0x0000_1040 → req_ready[2] same cycle; l2_req_valid=1, src=2, addr=0x0000_1040 next cycle; hold for 3 cycles with l2_req_ready=0 and fields stay stable.
- Cores 0–3 request simultaneously, distinct lines, l2_req_ready=1 → grant order 0,1,2,3 at cycles 0,2,4,6; rr_ptr ends at 0.
- Core 1 GETM 0x2000 busy; core 3 GETS 0x2010 (same line) → core 3 is not granted. L2 DATA_EXCL with dst=1 and resp_ready[1]=1 → core 3 is granted on the following cycle.
- Core 0 busy, reasserts req_valid; L2 response DATA dst=0 → resp_valid=4'b0001, resp_line matches L2; core 0 is granted one cycle after the response handshake, not in the same cycle.
- Response INV dst=2 → resp_valid=4'b0100, busy[2] unchanged (core 2 is still blocked).
- rst asserted while in FULL with l2_req_valid=1 → l2_req_valid=0 immediately (async); after release, busy=0 and rr_ptr=0.

Source files
------------

// File: rtl/coh_req_arb.sv
// Round-robin arbiter sharing the L2 coherence request port between NREQ L1D caches.
// Blocks grants to lines with an in-flight miss and routes L2 responses back by destination ID.
module coh_req_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned OFFSET_W = 5,
  parameter int unsigned CMD_W    = 3,
  parameter int unsigned LINE_W   = 256,
  parameter logic [CMD_W-1:0] CMD_DATA      = 'd2,
  parameter logic [CMD_W-1:0] CMD_DATA_EXCL = 'd3,
  localparam int unsigned SRC_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  input  logic [NREQ*32-1:0]    req_addr,
  output logic                  l2_req_valid,
  input  logic                  l2_req_ready,
  output logic [CMD_W-1:0]      l2_req_cmd,
  output logic [31:0]           l2_req_addr,
  output logic [SRC_W-1:0]      l2_req_src,
  input  logic                  l2_resp_valid,
  output logic                  l2_resp_ready,
  input  logic [SRC_W-1:0]      l2_resp_dst,
  input  logic [CMD_W-1:0]      l2_resp_cmd,
  input  logic [LINE_W-1:0]     l2_resp_line,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [CMD_W-1:0]      resp_cmd,
  output logic [LINE_W-1:0]     resp_line
);

  localparam int unsigned LA_W = 32 - OFFSET_W;
  localparam logic [31:0] OFF_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state;
  logic [NREQ-1:0]  busy;
  logic [LA_W-1:0]  busy_line [NREQ];
  logic [SRC_W-1:0] rr_ptr;

  logic [31:0]      req_addr_w [NREQ];
  logic [CMD_W-1:0] req_cmd_w  [NREQ];
  logic [LA_W-1:0]  req_line   [NREQ];
  logic [NREQ-1:0]  conflict;
  logic [NREQ-1:0]  eligible;
  logic             grant_any;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] rr_idx;
  logic             resp_clear;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr_w[i] = req_addr[i*32 +: 32];
      req_cmd_w[i]  = req_cmd[i*CMD_W +: CMD_W];
      req_line[i]   = req_addr_w[i][31:OFFSET_W];
    end
  end

  always_comb begin
    conflict = '0;
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (j != i && busy[j] && busy_line[j] == req_line[i]) conflict[i] = 1'b1;
      end
      if (l2_req_valid && l2_req_addr[31:OFFSET_W] == req_line[i]) conflict[i] = 1'b1;
      eligible[i] = req_valid[i] && !busy[i] && !conflict[i];
    end
  end

  // Scan downward from the farthest offset so the nearest eligible index at/after rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      rr_idx = rr_ptr + SRC_W'(k);
      if (eligible[rr_idx]) begin
        grant_any = 1'b1;
        grant_idx = rr_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == StEmpty && grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    resp_valid    = '0;
    l2_resp_ready = 1'b0;
    if (!rst) begin
      resp_valid[l2_resp_dst] = l2_resp_valid;
      l2_resp_ready           = resp_ready[l2_resp_dst];
    end
  end

  assign resp_cmd   = rst ? '0 : l2_resp_cmd;
  assign resp_line  = rst ? '0 : l2_resp_line;
  assign resp_clear = l2_resp_valid && l2_resp_ready &&
                      (l2_resp_cmd == CMD_DATA || l2_resp_cmd == CMD_DATA_EXCL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StEmpty;
      busy         <= '0;
      rr_ptr       <= '0;
      l2_req_valid <= 1'b0;
      l2_req_cmd   <= '0;
      l2_req_addr  <= '0;
      l2_req_src   <= '0;
      for (int i = 0; i < NREQ; i++) busy_line[i] <= '0;
    end else begin
      if (resp_clear) busy[l2_resp_dst] <= 1'b0;
      unique case (state)
        StEmpty: begin
          if (grant_any) begin
            state                <= StFull;
            l2_req_valid         <= 1'b1;
            l2_req_cmd           <= req_cmd_w[grant_idx];
            l2_req_addr          <= req_addr_w[grant_idx] & OFF_MASK;
            l2_req_src           <= grant_idx;
            busy[grant_idx]      <= 1'b1;
            busy_line[grant_idx] <= req_line[grant_idx];
            rr_ptr               <= grant_idx + 1'b1;
          end
        end
        StFull: begin
          if (l2_req_ready) begin
            state        <= StEmpty;
            l2_req_valid <= 1'b0;
          end
        end
        default: state <= StEmpty;
      endcase
    end
  end

  // A destination outside the core range would route a response to nobody.
  assert property (@(posedge clk) disable iff (rst) l2_resp_valid |-> int'(l2_resp_dst) < int'(NREQ));

endmodule

// File: tb/tb_coh_req_arb.sv
// Directed bench for coh_req_arb; expected L2 requests and core responses are queued at stimulus
// time and checked by a negedge monitor when the DUT presents them.
module tb_coh_req_arb;

  localparam logic [2:0] GETS = 3'd0, GETM = 3'd1, DATA = 3'd2, DATA_EXCL = 3'd3, INV = 3'd4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready;
  logic [11:0]  req_cmd;
  logic [127:0] req_addr;
  logic         l2_req_valid, l2_req_ready;
  logic [2:0]   l2_req_cmd;
  logic [31:0]  l2_req_addr;
  logic [1:0]   l2_req_src;
  logic         l2_resp_valid, l2_resp_ready;
  logic [1:0]   l2_resp_dst;
  logic [2:0]   l2_resp_cmd;
  logic [255:0] l2_resp_line;
  logic [3:0]   resp_valid, resp_ready;
  logic [2:0]   resp_cmd;
  logic [255:0] resp_line;

  coh_req_arb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_cmd(l2_req_cmd),
    .l2_req_addr(l2_req_addr), .l2_req_src(l2_req_src),
    .l2_resp_valid(l2_resp_valid), .l2_resp_ready(l2_resp_ready), .l2_resp_dst(l2_resp_dst),
    .l2_resp_cmd(l2_resp_cmd), .l2_resp_line(l2_resp_line),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_cmd(resp_cmd), .resp_line(resp_line)
  );

  always #5 clk = ~clk;

  typedef struct {logic [1:0] src; logic [2:0] cmd; logic [31:0] addr;} req_t;
  typedef struct {logic [3:0] onehot; logic [2:0] cmd; logic [255:0] line;} resp_t;

  req_t  exp_req[$];
  resp_t exp_resp[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [2:0] c, input logic [31:0] a);
    req_cmd[i*3 +: 3]   = c;
    req_addr[i*32 +: 32] = a;
  endtask

  task automatic push_req(input logic [1:0] s, input logic [2:0] c, input logic [31:0] a);
    req_t r;
    r.src = s; r.cmd = c; r.addr = a;
    exp_req.push_back(r);
  endtask

  function automatic logic [255:0] pat(input int d);
    return {8{32'hA5C3_0000 + 32'(d)}};
  endfunction

  // Drives a response for one cycle starting now; expectation goes on the queue.
  task automatic send_resp(input logic [1:0] d, input logic [2:0] c);
    resp_t r;
    l2_resp_valid = 1'b1; l2_resp_dst = d; l2_resp_cmd = c; l2_resp_line = pat(int'(d));
    resp_ready = 4'b0001 << d;
    r.onehot = 4'b0001 << d; r.cmd = c; r.line = pat(int'(d));
    exp_resp.push_back(r);
  endtask

  task automatic resp_off();
    l2_resp_valid = 1'b0; resp_ready = '0;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  // Monitor: compares every L2 request handshake and every core response against the queues.
  req_t  mr;
  resp_t ms;
  always @(negedge clk) begin
    if (!rst && l2_req_valid && l2_req_ready) begin
      if (exp_req.size() == 0) begin
        checks++; errors++;
        $display("FAIL l2_req_unexpected actual src=%0d addr=%0h required none", l2_req_src,
                 l2_req_addr);
      end else begin
        mr = exp_req.pop_front();
        chk("l2_req_src", 64'(l2_req_src), 64'(mr.src));
        chk("l2_req_cmd", 64'(l2_req_cmd), 64'(mr.cmd));
        chk("l2_req_addr", 64'(l2_req_addr), 64'(mr.addr));
      end
    end
    if (resp_valid != 4'b0000) begin
      if (exp_resp.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected actual=%b required 0000", resp_valid);
      end else begin
        ms = exp_resp.pop_front();
        chk("resp_valid", 64'(resp_valid), 64'(ms.onehot));
        chk("resp_cmd", 64'(resp_cmd), 64'(ms.cmd));
        chk_line("resp_line", resp_line, ms.line);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 4'b1111; req_cmd = '0; req_addr = '0; l2_req_ready = 1'b0;
    l2_resp_valid = 1'b1; l2_resp_dst = 2'd0; l2_resp_cmd = DATA; l2_resp_line = '1;
    resp_ready = 4'b1111;
    // Reset state: everything quiet even with inputs active.
    mid();
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_l2_req_valid", 64'(l2_req_valid), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_l2_resp_ready", 64'(l2_resp_ready), 64'h0);
    tick(); rst = 1'b0; req_valid = '0; resp_off();

    // Single request, held with l2_req_ready low.
    set_req(2, GETS, 32'h0000_1040); req_valid = 4'b0100;
    mid(); chk("t1_req_ready", 64'(req_ready), 64'h4);
    push_req(2'd2, GETS, 32'h0000_1040);
    tick(); req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      mid();
      chk("t1_l2_valid", 64'(l2_req_valid), 64'h1);
      chk("t1_l2_src", 64'(l2_req_src), 64'h2);
      chk("t1_l2_addr", 64'(l2_req_addr), 64'h1040);
      chk("t1_full_ready", 64'(req_ready), 64'h0);
      tick();
    end
    l2_req_ready = 1'b1;
    mid(); tick();
    mid(); chk("t1_l2_valid_drop", 64'(l2_req_valid), 64'h0);

    // All four cores at once: grants 0,1,2,3 every other cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(i, GETS, 32'((i + 1) << 8));
      push_req(2'(i), GETS, 32'((i + 1) << 8));
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      mid(); chk("t2_grant_seq", 64'(req_ready), (c % 2 == 0) ? 64'(1 << (c / 2)) : 64'h0);
      tick();
    end
    req_valid = '0;
    for (int d = 0; d < 4; d++) begin
      send_resp(2'(d), DATA);
      mid(); chk("t2_l2_resp_ready", 64'(l2_resp_ready), 64'h1);
      tick();
    end
    resp_off();
    // rr_ptr wrapped to 0: core 0 beats core 3.
    req_valid = 4'b1001;
    mid(); chk("t2_rr_wrap", 64'(req_ready), 64'h1);
    push_req(2'd0, GETS, 32'h100);
    tick(); req_valid = '0; mid(); tick();

    // Line conflict: core 3 blocked behind core 1 until DATA_EXCL arrives.
    do_reset();
    set_req(1, GETM, 32'h0000_2000); req_valid = 4'b0010;
    mid(); chk("t3_grant1", 64'(req_ready), 64'h2);
    push_req(2'd1, GETM, 32'h0000_2000);
    tick(); set_req(3, GETS, 32'h0000_2010); req_valid = 4'b1000;
    mid(); tick();
    mid(); chk("t3_conflict_block", 64'(req_ready), 64'h0);
    tick(); send_resp(2'd1, DATA_EXCL);
    mid(); chk("t3_block_resp_cycle", 64'(req_ready), 64'h0);
    tick(); resp_off();
    mid(); chk("t3_grant3", 64'(req_ready), 64'h8);
    push_req(2'd3, GETS, 32'h0000_2000);
    tick(); req_valid = '0; mid(); tick();

    // Busy core re-requests; granted one cycle after its DATA response.
    set_req(0, GETS, 32'h0000_3000); req_valid = 4'b0001;
    mid(); chk("t4_grant0", 64'(req_ready), 64'h1);
    push_req(2'd0, GETS, 32'h0000_3000);
    tick(); mid(); tick();
    mid(); chk("t4_busy_block", 64'(req_ready), 64'h0);
    tick(); send_resp(2'd0, DATA);
    mid(); chk("t4_resp_onehot", 64'(resp_valid), 64'h1);
    chk("t4_same_cycle_block", 64'(req_ready), 64'h0);
    tick(); resp_off();
    mid(); chk("t4_regrant", 64'(req_ready), 64'h1);
    push_req(2'd0, GETS, 32'h0000_3000);
    tick(); req_valid = '0; mid(); tick();

    // INV leaves busy set.
    set_req(2, GETS, 32'h0000_5000); req_valid = 4'b0100;
    mid(); chk("t5_grant2", 64'(req_ready), 64'h4);
    push_req(2'd2, GETS, 32'h0000_5000);
    tick(); mid(); tick();
    send_resp(2'd2, INV);
    mid(); chk("t5_resp_onehot", 64'(resp_valid), 64'h4);
    tick(); resp_off();
    mid(); chk("t5_inv_still_busy", 64'(req_ready), 64'h0);
    tick(); req_valid = '0;

    // Asynchronous reset while FULL.
    l2_req_ready = 1'b0;
    set_req(1, GETM, 32'h0000_6000); req_valid = 4'b0010;
    mid(); chk("t6_grant1", 64'(req_ready), 64'h2);
    tick(); req_valid = '0;
    mid(); chk("t6_full", 64'(l2_req_valid), 64'h1);
    #2 rst = 1'b1;
    #1 chk("t6_async_drop", 64'(l2_req_valid), 64'h0);
    tick(); rst = 1'b0; l2_req_ready = 1'b1;
    set_req(2, GETS, 32'h0000_7000); set_req(3, GETS, 32'h0000_8000);
    req_valid = 4'b1110;
    mid(); chk("t6_rr_cleared", 64'(req_ready), 64'h2);
    push_req(2'd1, GETM, 32'h0000_6000);
    tick(); mid(); tick();
    mid(); chk("t6_busy_cleared", 64'(req_ready), 64'h4);
    push_req(2'd2, GETS, 32'h0000_7000);
    tick(); req_valid = '0; mid(); tick();

    for (int c = 0; c < 10 && (exp_req.size() != 0 || exp_resp.size() != 0); c++) tick();
    chk("drain_req_queue", 64'(exp_req.size()), 64'h0);
    chk("drain_resp_queue", 64'(exp_resp.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
